// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit frame state machine.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    RECOVER = 3'd5
  } state_t;

  localparam int   DATA_BITS       = 8;
  localparam int   FRAME_BITS_BASE = 10;
  localparam logic LINE_IDLE       = 1'b1;
  localparam logic START_LVL       = 1'b0;

  // Tick counter width; a one-cycle bit still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_frame_sm_if.sv
// Byte handshake into the transmitter.
interface uart_tx_frame_sm_if;
  import uart_pkg::*;

  // A byte transfers on a clk edge where tx_valid && tx_ready; the master holds
  // tx_data/tx_valid stable until then, and tx_valid while tx_ready=0 has no effect.
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period tick counter: bit_end pulses on the last clk of each bit time.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int            CW   = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame_sm.sv
// UART frame transmitter: start, 8 data bits LSB first, parity, stop bit(s),
// with a receiver-driven abort that parks the line high for one bit time.
module uart_tx_frame_sm
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  uart_tx_frame_sm_if.slave        tx_if,
  input  logic                     mreset_in,
  output logic                     tx_out,
  output logic                     tx_busy,
  output logic                     tx_done,
  output logic                     tx_abort,
  output logic [2:0]               dbg_state
);

  state_t               state_q, state_d;
  logic                 tx_out_q, tx_out_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 done_q, done_d;
  logic                 abort_q, abort_d;

  logic bit_end, last_stop, ready, accept, abort_req;

  assign last_stop = (stop_cnt_q == 1'(STOP_BITS - 1));
  // Ready on the final stop clk too, so a waiting byte starts with no idle gap.
  assign ready     = (state_q == IDLE) || ((state_q == STOP) && bit_end && last_stop);
  assign accept    = tx_if.tx_valid && ready;
  // The receiver pulses Mreset at every normal frame end, so STOP must ignore it.
  assign abort_req = mreset_in && ((state_q == START) || (state_q == DATA) || (state_q == PARITY));

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .rst_n   (reset),
    .clear   ((state_q == IDLE) || abort_req),
    .enable  (state_q != IDLE),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d    = state_q;
    tx_out_d   = tx_out_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    if (abort_req) begin
      state_d  = RECOVER;
      tx_out_d = LINE_IDLE;
      abort_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_out_d = LINE_IDLE;
          if (accept) begin
            state_d    = START;
            tx_out_d   = START_LVL;
            shift_d    = tx_if.tx_data;
            parity_d   = (^tx_if.tx_data) ^ (PARITY_ODD != 0);
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
          end
        end
        START: if (bit_end) begin
          state_d   = DATA;
          tx_out_d  = shift_q[0];
          bit_cnt_d = '0;
        end
        DATA: if (bit_end) begin
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            state_d  = PARITY;
            tx_out_d = parity_q;
          end else begin
            shift_d   = shift_q >> 1;
            tx_out_d  = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        PARITY: if (bit_end) begin
          state_d    = STOP;
          tx_out_d   = LINE_IDLE;
          stop_cnt_d = 1'b0;
        end
        STOP: if (bit_end) begin
          if (last_stop) begin
            done_d = 1'b1;
            if (accept) begin
              state_d    = START;
              tx_out_d   = START_LVL;
              shift_d    = tx_if.tx_data;
              parity_d   = (^tx_if.tx_data) ^ (PARITY_ODD != 0);
              bit_cnt_d  = '0;
              stop_cnt_d = 1'b0;
            end else begin
              state_d  = IDLE;
              tx_out_d = LINE_IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        RECOVER: begin
          tx_out_d = LINE_IDLE;
          if (bit_end) state_d = IDLE;
        end
        default: begin
          state_d  = IDLE;
          tx_out_d = LINE_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tx_out_q   <= LINE_IDLE;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_out_q   <= tx_out_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  assign tx_if.tx_ready = ready;
  assign tx_out         = tx_out_q;
  assign tx_busy        = (state_q != IDLE);
  assign tx_done        = done_q;
  assign tx_abort       = abort_q;
  assign dbg_state      = state_q;

endmodule

// File: doc/uart_tx_frame_sm.md
Name: uart_tx_frame_sm

Overview:
Serial transmitter feeding the receiver state machine's Rx_in input. It accepts a byte over a valid/ready handshake and serialises it, LSB first, as one frame: start, 8 data, parity, stop. The receiver's Mreset output is fed back so a receiver-side error aborts the frame in flight. One clk per bit by default, matching the receiver's bit-rate clock.

Parameters:
CLKS_PER_BIT, 1, clk cycles each serial bit is held; must be >= 1.
PARITY_ODD, 0, 0 = even parity bit (^data), 1 = odd parity bit (~^data).
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
clk  in  1  bit-rate clock, shared with the receiver.
reset  in  1  asynchronous, active-low reset; 0 = reset.
tx_data  in  8  byte to send; sampled on accept.
tx_valid  in  1  tx_data is valid.
tx_ready  out  1  block can accept a byte this cycle.
mreset_in  in  1  Mreset from the receiver; abort request.
tx_out  out  1  serial line; idles high.
tx_busy  out  1  frame or recovery in progress.
tx_done  out  1  1-cycle pulse: frame fully sent.
tx_abort  out  1  1-cycle pulse: frame aborted.

Behaviour:
- Reset (async, reset=0): state IDLE, tx_out=1, tx_busy=0, tx_done=0, tx_abort=0, all counters 0. tx_out must go high without waiting for a clk edge.
- States: IDLE, START, DATA, PARITY, STOP, RECOVER.
- Accept: occurs when tx_valid && tx_ready at a clk edge. tx_data is latched into shift_reg, and parity_bit = (^tx_data) ^ PARITY_ODD.
- tx_ready = 1 in IDLE, and in the final cycle of the last stop bit (back-to-back). It is 0 in all other states.
- Latency: tx_out is registered. tx_out=0 (START) from the edge of accept.
- Bit timing:
  - A tick counter counts 0..CLKS_PER_BIT-1 and advances the bit on terminal count.
  - Counter width = max(1, clog2(CLKS_PER_BIT)).
  - Each bit is held exactly CLKS_PER_BIT cycles.
- Bit sequence:
  - START: tx_out=0.
  - DATA: tx_out=shift_reg[0]; shift right on each bit advance. bit_cnt runs 0..7 and wraps to PARITY after 7.
  - PARITY: tx_out=parity_bit.
  - STOP: tx_out=1 for STOP_BITS bit times.
- Frame length = (10+STOP_BITS)*CLKS_PER_BIT cycles.
- End of frame:
  - At the end of the last stop bit, tx_done pulses for one cycle (the edge where the stop bit completes).
  - Next state is START if accepting, else IDLE.
  - A back-to-back frame has no idle bit between the stop bit and the next start bit. The receiver's Stop->Start path supports this.
- Abort:
  - mreset_in=1 sampled in START, DATA or PARITY causes the following at the next edge: state RECOVER, tx_out=1, tx_abort pulses, and the frame is discarded (no tx_done).
  - mreset_in is ignored in IDLE and STOP; the receiver pulses it at every normal frame end.
- RECOVER: tx_out=1 for one full bit time (CLKS_PER_BIT cycles), tx_ready=0, then IDLE.
- tx_busy = 1 in every state except IDLE, including the last stop cycle that overlaps a back-to-back accept.
- tx_valid while tx_ready=0 is ignored. The upstream block holds tx_data/tx_valid until accepted.
- Simultaneous async reset and anything: reset wins.

Decomposition:
- Shared package uart_pkg holds:
  - state enum/localparams (IDLE..RECOVER, 3 bits);
  - DATA_BITS=8;
  - FRAME_BITS_BASE=10;
  - line level constants LINE_IDLE=1 and START_LVL=0.
- One sub-module, uart_bit_timer:
  - tick counter with inputs clear and enable;
  - parameter CLKS_PER_BIT;
  - output bit_end, a 1-cycle pulse on terminal count.
  - The frame FSM stays in uart_tx_frame_sm.

Test Plan:
- Defaults, send 0xA5 -> tx_out over 11 cycles = 0,1,0,1,0,0,1,0,1,0,1 (parity 0). tx_done pulses once at cycle 11; tx_ready returns 1.
- Defaults, send 0x07 -> parity bit 1. Frame 0,1,1,1,0,0,0,0,0,1,1. With PARITY_ODD=1, parity bit 0.
- CLKS_PER_BIT=4, STOP_BITS=2, send 0x3C -> each level held 4 cycles, 48-cycle frame. tx_busy high for all 48 cycles.
- tx_valid held high with 0x55 then 0xAA -> second start bit begins the cycle right after the first stop bit, no idle gap. Two tx_done pulses 11 cycles apart.
- mreset_in=1 during d3 of 0xF0 -> tx_out=1 next cycle, tx_abort pulse, no tx_done. tx_ready=0 for CLKS_PER_BIT cycles, then 1. mreset_in during STOP leaves the frame intact.
- reset driven low mid-parity bit, between clk edges -> tx_out=1 immediately, state IDLE, tx_busy=0. After reset release, 0x81 is sent correctly.
